// File: rtl/eth_tx_fsm_if.sv
// Stream bundle for the transmit framer: frame-word handshake in,
// 32-bit beat stream out, plus the downstream stall.
interface eth_tx_fsm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_WIDTH = 130
);
    logic [FIFO_WIDTH-1:0] in_word;
    logic                  in_valid;
    logic                  in_ready;
    logic                  stall;
    logic [DATA_WIDTH-1:0] outdata;
    logic                  outsop;
    logic                  outeop;
    logic                  outvalid;

    modport master (
        output in_word,
        output in_valid,
        input  in_ready,
        output stall,
        input  outdata,
        input  outsop,
        input  outeop,
        input  outvalid
    );

    modport slave (
        input  in_word,
        input  in_valid,
        output in_ready,
        input  stall,
        output outdata,
        output outsop,
        output outeop,
        output outvalid
    );
endinterface

// File: rtl/eth_tx_fsm.sv
// Per-port transmit framer: one packed frame word in, four 32-bit
// beats out (dest, src, payload, crc), then a fixed inter-packet gap.
module eth_tx_fsm #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_WIDTH = 130,
    parameter int IPG_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    eth_tx_fsm_if.slave          bus,
    output logic                 busy,
    output logic                 drop_err,
    output logic [CNT_WIDTH-1:0] tx_frame_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int DST_LSB = 1;
    localparam int PAY_LSB = DST_LSB + DATA_WIDTH;
    localparam int SRC_LSB = PAY_LSB + DATA_WIDTH;
    localparam int CRC_LSB = SRC_LSB + DATA_WIDTH;
    localparam int EOP_BIT = FIFO_WIDTH - 1;

    localparam logic [3:0] IPG_LOAD = 4'(IPG_CYCLES);
    localparam bit         HAS_GAP  = (IPG_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEST,
        S_SRC,
        S_DATA,
        S_CRC,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [FIFO_WIDTH-2:1]  word_q;
    logic [3:0]             gap_q;
    logic                   rdy_q;
    logic                   drop_q;
    logic [CNT_WIDTH-1:0]   frame_q;
    logic [CNT_WIDTH-1:0]   dropc_q;

    logic                   accept;
    logic                   malformed;
    logic                   crc_done;

    logic [DATA_WIDTH-1:0]  data_d;
    logic                   sop_d;
    logic                   eop_d;
    logic                   valid_d;

    // The sop/eop markers travel with the word; both must be set.
    assign accept    = bus.in_valid & rdy_q;
    assign malformed = ~bus.in_word[0] | ~bus.in_word[EOP_BIT];
    assign crc_done  = (state_q == S_CRC) & ~bus.stall;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: beats advance only when the downstream is not stalling.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept && !malformed) begin
                    state_d = S_DEST;
                end
            end
            S_DEST: begin
                if (!bus.stall) state_d = S_SRC;
            end
            S_SRC: begin
                if (!bus.stall) state_d = S_DATA;
            end
            S_DATA: begin
                if (!bus.stall) state_d = S_CRC;
            end
            S_CRC: begin
                if (!bus.stall) state_d = HAS_GAP ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_q <= 4'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat outputs decoded from the held word; zero outside beat states.
    always_comb begin
        data_d  = '0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            S_DEST: begin
                data_d  = word_q[DST_LSB +: DATA_WIDTH];
                sop_d   = 1'b1;
                valid_d = 1'b1;
            end
            S_SRC: begin
                data_d  = word_q[SRC_LSB +: DATA_WIDTH];
                valid_d = 1'b1;
            end
            S_DATA: begin
                data_d  = word_q[PAY_LSB +: DATA_WIDTH];
                valid_d = 1'b1;
            end
            S_CRC: begin
                data_d  = word_q[CRC_LSB +: DATA_WIDTH];
                eop_d   = 1'b1;
                valid_d = 1'b1;
            end
            default: begin
                data_d  = '0;
            end
        endcase
    end

    // Held word, gap timer, ready flag, drop pulse and wrapping counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            gap_q   <= '0;
            rdy_q   <= 1'b0;
            drop_q  <= 1'b0;
            frame_q <= '0;
            dropc_q <= '0;
        end else begin
            rdy_q  <= (state_d == S_IDLE);
            drop_q <= accept & malformed;
            if (accept && !malformed) begin
                word_q <= bus.in_word[FIFO_WIDTH-2:1];
            end
            if (accept && malformed) begin
                dropc_q <= dropc_q + CNT_WIDTH'(1);
            end
            if (crc_done) begin
                frame_q <= frame_q + CNT_WIDTH'(1);
                gap_q   <= IPG_LOAD;
            end else if (state_q == S_GAP) begin
                gap_q   <= gap_q - 4'd1;
            end
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.outdata   = data_d;
    assign bus.outsop    = sop_d;
    assign bus.outeop    = eop_d;
    assign bus.outvalid  = valid_d;
    assign busy          = (state_q != S_IDLE);
    assign drop_err      = drop_q;
    assign tx_frame_cnt  = frame_q;
    assign drop_cnt      = dropc_q;

endmodule
